// File: rtl/wm8731_cmd_scheduler.sv
// Command sequencer for the WM8731 I2C controller: plays the power-up init ROM,
// then arbitrates mute/volume updates with bounded retry on NACK.
module wm8731_cmd_scheduler #(
  parameter int unsigned TOTAL_CMD = 9,
  parameter int unsigned MAX_RETRY = 3,
  parameter logic [7:0]  DEV_ADDR  = 8'h34,
  parameter logic [6:0]  VOL_RESET = 7'h74
) (
  input  logic        clk_i2c,
  input  logic        reset,
  input  logic        vol_req,
  input  logic [6:0]  vol_val,
  input  logic        mute_req,
  input  logic        mute_on,
  output logic [23:0] i2c_data,
  output logic        i2c_go,
  input  logic        i2c_end,
  input  logic [2:0]  i2c_ack,
  output logic        init_done,
  output logic        busy,
  output logic        error,
  output logic [3:0]  cmd_index
);

  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {ARB, WAIT, CHECK} state_t;
  typedef enum logic [1:0] {SRC_INIT, SRC_MUTE, SRC_VOL} src_t;

  state_t        state, state_nxt;
  src_t          src, src_nxt;
  logic [1:0]    blank, blank_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic [2:0]    ack_q, ack_q_nxt;
  logic          go_nxt;
  logic [23:0]   data_nxt;
  logic          done_nxt;
  logic          err_nxt;
  logic [3:0]    idx_nxt;
  logic          launch;
  logic          vol_launch;
  logic          mute_launch;

  logic          vol_pend;
  logic          mute_pend;
  logic [6:0]    vol_shadow;
  logic          mute_shadow;
  logic [15:0]   init_word;

  // Init ROM: {reg[6:0], data[8:0]}; volume entries track the live shadow
  always_comb begin
    init_word = '0;
    case (cmd_index)
      4'd0:    init_word = {7'h0F, 9'h000};
      4'd1:    init_word = {7'h06, 9'h000};
      4'd2:    init_word = {7'h08, 9'h002};
      4'd3:    init_word = {7'h02, 2'b00, vol_shadow};
      4'd4:    init_word = {7'h03, 2'b00, vol_shadow};
      4'd5:    init_word = {7'h07, 9'h001};
      4'd6:    init_word = {7'h09, 9'h001};
      4'd7:    init_word = {7'h04, 9'h016};
      4'd8:    init_word = {7'h05, 9'h006};
      default: init_word = '0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    src_nxt     = src;
    blank_nxt   = blank;
    retry_nxt   = retry;
    ack_q_nxt   = ack_q;
    go_nxt      = i2c_go;
    data_nxt    = i2c_data;
    done_nxt    = init_done;
    err_nxt     = error;
    idx_nxt     = cmd_index;
    launch      = 1'b0;
    vol_launch  = 1'b0;
    mute_launch = 1'b0;

    case (state)
      ARB: begin
        if (!init_done) begin
          data_nxt = {DEV_ADDR, init_word};
          src_nxt  = SRC_INIT;
          launch   = 1'b1;
        end else if (mute_pend) begin
          data_nxt    = {DEV_ADDR, 7'h05, 9'h006 | {5'b00000, mute_shadow, 3'b000}};
          src_nxt     = SRC_MUTE;
          launch      = 1'b1;
          mute_launch = 1'b1;
        end else if (vol_pend) begin
          data_nxt   = {DEV_ADDR, 7'h02, 2'b10, vol_shadow};
          src_nxt    = SRC_VOL;
          launch     = 1'b1;
          vol_launch = 1'b1;
        end
        if (launch) begin
          go_nxt    = 1'b1;
          blank_nxt = '0;
          state_nxt = WAIT;
        end
      end

      // i2c_end may still reflect the previous transfer for two cycles after go rises
      WAIT: begin
        if (blank == 2'd2) begin
          if (i2c_end) begin
            go_nxt    = 1'b0;
            ack_q_nxt = i2c_ack;
            state_nxt = CHECK;
          end
        end else begin
          blank_nxt = blank + 2'd1;
        end
      end

      CHECK: begin
        if ((ack_q != '0) && (retry < RW'(MAX_RETRY))) begin
          retry_nxt = retry + RW'(1);
          go_nxt    = 1'b1;
          blank_nxt = '0;
          state_nxt = WAIT;
        end else begin
          retry_nxt = '0;
          if (ack_q != '0) begin
            err_nxt = 1'b1;
          end
          if (src == SRC_INIT) begin
            idx_nxt = cmd_index + 4'd1;
            if (cmd_index == 4'(TOTAL_CMD - 1)) begin
              done_nxt = 1'b1;
            end
          end
          state_nxt = ARB;
        end
      end

      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk_i2c) begin
    if (reset) begin
      state     <= ARB;
      src       <= SRC_INIT;
      blank     <= '0;
      retry     <= '0;
      ack_q     <= '0;
      i2c_go    <= 1'b0;
      i2c_data  <= '0;
      init_done <= 1'b0;
      error     <= 1'b0;
      cmd_index <= '0;
    end else begin
      state     <= state_nxt;
      src       <= src_nxt;
      blank     <= blank_nxt;
      retry     <= retry_nxt;
      ack_q     <= ack_q_nxt;
      i2c_go    <= go_nxt;
      i2c_data  <= data_nxt;
      init_done <= done_nxt;
      error     <= err_nxt;
      cmd_index <= idx_nxt;
    end
  end

  // A new request in the launch cycle keeps its flag set so the newer value is sent too
  always_ff @(posedge clk_i2c) begin
    if (reset) begin
      vol_pend    <= 1'b0;
      mute_pend   <= 1'b0;
      vol_shadow  <= VOL_RESET;
      mute_shadow <= 1'b0;
    end else begin
      if (vol_req) begin
        vol_pend   <= 1'b1;
        vol_shadow <= vol_val;
      end else if (vol_launch) begin
        vol_pend <= 1'b0;
      end
      if (mute_req) begin
        mute_pend   <= 1'b1;
        mute_shadow <= mute_on;
      end else if (mute_launch) begin
        mute_pend <= 1'b0;
      end
    end
  end

  assign busy = (state != ARB) | ~init_done | vol_pend | mute_pend;

endmodule

// File: tb/tb_wm8731_cmd_scheduler.sv
// Scoreboard bench for wm8731_cmd_scheduler with a behavioural I2C controller model.
module tb_wm8731_cmd_scheduler;

  logic        clk_i2c = 1'b0;
  logic        reset = 1'b1;
  logic        vol_req = 1'b0;
  logic [6:0]  vol_val = '0;
  logic        mute_req = 1'b0;
  logic        mute_on = 1'b0;
  logic        i2c_end = 1'b0;
  logic [2:0]  i2c_ack = '0;
  logic [23:0] i2c_data;
  logic        i2c_go;
  logic        init_done;
  logic        busy;
  logic        error;
  logic [3:0]  cmd_index;

  int unsigned checks = 0;
  int unsigned passed = 0;

  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  int unsigned gap_q[$];
  int unsigned hi_q[$];
  logic [2:0]  ack_plan[$];

  int unsigned end_lat = 3;
  int unsigned low_cnt = 0;
  int unsigned hi_cnt = 0;
  int unsigned stable_err = 0;
  logic        go_prev = 1'b0;
  logic [23:0] data_prev = '0;
  logic [2:0]  cur_ack = '0;

  logic [23:0] golden [9] = '{24'h341E00, 24'h340C00, 24'h341002, 24'h340474, 24'h340674,
                              24'h340E01, 24'h341201, 24'h340816, 24'h340A06};

  wm8731_cmd_scheduler #(
    .TOTAL_CMD(9),
    .MAX_RETRY(3),
    .DEV_ADDR (8'h34),
    .VOL_RESET(7'h74)
  ) dut (
    .clk_i2c  (clk_i2c),
    .reset    (reset),
    .vol_req  (vol_req),
    .vol_val  (vol_val),
    .mute_req (mute_req),
    .mute_on  (mute_on),
    .i2c_data (i2c_data),
    .i2c_go   (i2c_go),
    .i2c_end  (i2c_end),
    .i2c_ack  (i2c_ack),
    .init_done(init_done),
    .busy     (busy),
    .error    (error),
    .cmd_index(cmd_index)
  );

  always #5 clk_i2c = ~clk_i2c;

  // Controller model and monitor: raises end end_lat cycles into a transfer
  always @(negedge clk_i2c) begin
    if (i2c_go) begin
      if (!go_prev) begin
        obs_q.push_back(i2c_data);
        gap_q.push_back(low_cnt);
        cur_ack = 3'b000;
        if (ack_plan.size() > 0) cur_ack = ack_plan.pop_front();
        hi_cnt = 0;
      end else if (i2c_data !== data_prev) begin
        stable_err++;
      end
      hi_cnt++;
      low_cnt = 0;
      if (hi_cnt >= end_lat) begin
        i2c_end = 1'b1;
        i2c_ack = cur_ack;
      end
    end else begin
      if (go_prev) hi_q.push_back(hi_cnt);
      low_cnt++;
      hi_cnt = 0;
      i2c_end = 1'b0;
      i2c_ack = 3'b000;
    end
    go_prev = i2c_go;
    data_prev = i2c_data;
  end

  function automatic logic [23:0] init_exp(input int unsigned i, input logic [6:0] v);
    logic [23:0] w;
    w = golden[i];
    if (i == 3) w = {8'h34, 7'h02, 2'b00, v};
    if (i == 4) w = {8'h34, 7'h03, 2'b00, v};
    return w;
  endfunction

  function automatic logic [23:0] vol_word(input logic [6:0] v);
    return {8'h34, 7'h02, 2'b10, v};
  endfunction

  task automatic next_obs(output logic [23:0] word, output int unsigned gap, output bit ok);
    int unsigned n = 0;
    word = '0;
    gap = 0;
    ok = 1'b0;
    while (obs_q.size() == 0 && n < 300) begin
      @(negedge clk_i2c);
      n++;
    end
    if (obs_q.size() != 0) begin
      word = obs_q.pop_front();
      gap = gap_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    int unsigned n = 0;
    @(negedge clk_i2c);
    while (busy && n < 1000) begin
      @(negedge clk_i2c);
      n++;
    end
    ok = !busy;
  endtask

  task automatic do_reset();
    @(negedge clk_i2c);
    reset = 1'b1;
    repeat (2) @(negedge clk_i2c);
    obs_q.delete();
    gap_q.delete();
    hi_q.delete();
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i2c);
    checks++; if (i2c_go !== 1'b0) $display("FAIL rst_go: got %b expected 0", i2c_go); else passed++;
    checks++; if (i2c_data !== 24'h0) $display("FAIL rst_data: got %h expected 000000", i2c_data); else passed++;
    checks++; if (init_done !== 1'b0) $display("FAIL rst_init_done: got %b expected 0", init_done); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL rst_error: got %b expected 0", error); else passed++;
    checks++; if (cmd_index !== 4'd0) $display("FAIL rst_cmd_index: got %0d expected 0", cmd_index); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL rst_busy: got %b expected 1", busy); else passed++;
    reset = 1'b0;
    @(posedge clk_i2c);
    #1;
    checks++; if (i2c_go !== 1'b1) $display("FAIL first_go: got %b expected 1", i2c_go); else passed++;
  endtask

  task automatic test_init();
    logic [23:0] o, e;
    int unsigned g;
    bit ok;
    for (int unsigned i = 0; i < 9; i++) exp_q.push_back(golden[i]);
    for (int unsigned i = 0; i < 9; i++) begin
      e = exp_q.pop_front();
      next_obs(o, g, ok);
      checks++; if (!ok || o !== e) $display("FAIL init_word%0d: got %h (ok=%0d) expected %h", i, o, ok, e); else passed++;
      if (i > 0) begin
        checks++; if (g !== 2) $display("FAIL init_gap%0d: got %0d expected 2", i, g); else passed++;
      end
    end
    wait_idle(ok);
    checks++; if (!ok) $display("FAIL init_idle: busy stuck at %b expected 0", busy); else passed++;
    checks++; if (init_done !== 1'b1) $display("FAIL init_done: got %b expected 1", init_done); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL init_error: got %b expected 0", error); else passed++;
    checks++; if (cmd_index !== 4'd9) $display("FAIL init_cmd_index: got %0d expected 9", cmd_index); else passed++;
    checks++; if (obs_q.size() != 0) $display("FAIL init_extra: got %0d extra pulses expected 0", obs_q.size()); else passed++;
  endtask

  task automatic test_volume();
    logic [23:0] o, e;
    int unsigned g, n;
    bit ok;
    end_lat = 1;
    hi_q.delete();
    @(negedge clk_i2c);
    vol_req = 1'b1;
    vol_val = 7'h50;
    exp_q.push_back(24'h340550);
    @(posedge clk_i2c);
    #1;
    checks++; if (i2c_go !== 1'b0) $display("FAIL vol_lat_early: got %b expected 0", i2c_go); else passed++;
    @(negedge clk_i2c);
    vol_req = 1'b0;
    @(posedge clk_i2c);
    #1;
    checks++; if (i2c_go !== 1'b1) $display("FAIL vol_lat_go: got %b expected 1", i2c_go); else passed++;
    e = exp_q.pop_front();
    next_obs(o, g, ok);
    checks++; if (!ok || o !== e) $display("FAIL vol_word: got %h (ok=%0d) expected %h", o, ok, e); else passed++;
    n = 0;
    while (i2c_go && n < 100) begin
      @(negedge clk_i2c);
      n++;
    end
    checks++; if (busy !== 1'b1) $display("FAIL vol_busy_check: got %b expected 1", busy); else passed++;
    @(negedge clk_i2c);
    checks++; if (busy !== 1'b0) $display("FAIL vol_busy_fall: got %b expected 0", busy); else passed++;
    checks++; if (hi_q.size() == 0 || hi_q[0] !== 3) $display("FAIL vol_go_width: got %0d expected 3", hi_q.size() ? hi_q[0] : 0); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL vol_error: got %b expected 0", error); else passed++;
    end_lat = 3;
  endtask

  task automatic test_retry_recover();
    logic [23:0] o, e;
    int unsigned g;
    bit ok;
    ack_plan = '{3'b001, 3'b001, 3'b000};
    @(negedge clk_i2c);
    vol_req = 1'b1;
    vol_val = 7'h11;
    for (int unsigned i = 0; i < 3; i++) exp_q.push_back(vol_word(7'h11));
    @(negedge clk_i2c);
    vol_req = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      next_obs(o, g, ok);
      checks++; if (!ok || o !== e) $display("FAIL rec_word%0d: got %h (ok=%0d) expected %h", i, o, ok, e); else passed++;
      if (i > 0) begin
        checks++; if (g !== 1) $display("FAIL rec_gap%0d: got %0d expected 1", i, g); else passed++;
      end
    end
    wait_idle(ok);
    checks++; if (!ok) $display("FAIL rec_idle: busy stuck at %b expected 0", busy); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL rec_error: got %b expected 0", error); else passed++;
    checks++; if (obs_q.size() != 0) $display("FAIL rec_extra: got %0d extra pulses expected 0", obs_q.size()); else passed++;
  endtask

  task automatic test_retry_fatal();
    logic [23:0] o, e;
    int unsigned g;
    bit ok;
    ack_plan = '{3'b010, 3'b010, 3'b010, 3'b010};
    do_reset();
    for (int unsigned i = 0; i < 4; i++) exp_q.push_back(24'h341E00);
    for (int unsigned i = 1; i < 9; i++) exp_q.push_back(golden[i]);
    for (int unsigned i = 0; i < 12; i++) begin
      e = exp_q.pop_front();
      next_obs(o, g, ok);
      checks++; if (!ok || o !== e) $display("FAIL fatal_word%0d: got %h (ok=%0d) expected %h", i, o, ok, e); else passed++;
      if (i >= 1 && i <= 3) begin
        checks++; if (g !== 1) $display("FAIL fatal_gap%0d: got %0d expected 1", i, g); else passed++;
      end
      if (i == 3) begin
        checks++; if (error !== 1'b0) $display("FAIL fatal_err_early: got %b expected 0", error); else passed++;
      end
      if (i == 4) begin
        checks++; if (g !== 2) $display("FAIL fatal_gap_next: got %0d expected 2", g); else passed++;
        checks++; if (error !== 1'b1) $display("FAIL fatal_error: got %b expected 1", error); else passed++;
        checks++; if (cmd_index !== 4'd1) $display("FAIL fatal_cmd_index: got %0d expected 1", cmd_index); else passed++;
      end
    end
    wait_idle(ok);
    checks++; if (!ok || init_done !== 1'b1) $display("FAIL fatal_init_done: got %b expected 1", init_done); else passed++;
    checks++; if (error !== 1'b1) $display("FAIL fatal_sticky: got %b expected 1", error); else passed++;
  endtask

  task automatic test_simultaneous();
    logic [23:0] o, e;
    int unsigned g;
    bit ok;
    do_reset();
    @(negedge clk_i2c);
    mute_req = 1'b1;
    mute_on = 1'b1;
    vol_req = 1'b1;
    vol_val = 7'h20;
    for (int unsigned i = 0; i < 9; i++) exp_q.push_back(init_exp(i, 7'h20));
    exp_q.push_back(24'h340A0E);
    exp_q.push_back(vol_word(7'h20));
    @(negedge clk_i2c);
    mute_req = 1'b0;
    vol_req = 1'b0;
    for (int unsigned i = 0; i < 11; i++) begin
      e = exp_q.pop_front();
      next_obs(o, g, ok);
      checks++; if (!ok || o !== e) $display("FAIL simul_word%0d: got %h (ok=%0d) expected %h", i, o, ok, e); else passed++;
    end
    wait_idle(ok);
    checks++; if (!ok || error !== 1'b0) $display("FAIL simul_error: got %b expected 0", error); else passed++;
  endtask

  task automatic test_coalesce();
    logic [23:0] o, e;
    int unsigned g;
    bit ok;
    do_reset();
    @(negedge clk_i2c);
    vol_req = 1'b1;
    vol_val = 7'h10;
    @(negedge clk_i2c);
    vol_req = 1'b0;
    repeat (2) @(negedge clk_i2c);
    vol_req = 1'b1;
    vol_val = 7'h30;
    @(negedge clk_i2c);
    vol_req = 1'b0;
    for (int unsigned i = 0; i < 9; i++) exp_q.push_back(init_exp(i, 7'h30));
    exp_q.push_back(24'h340530);
    for (int unsigned i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      next_obs(o, g, ok);
      checks++; if (!ok || o !== e) $display("FAIL coal_word%0d: got %h (ok=%0d) expected %h", i, o, ok, e); else passed++;
    end
    wait_idle(ok);
    repeat (20) @(negedge clk_i2c);
    checks++; if (obs_q.size() != 0) $display("FAIL coal_extra: got %0d extra pulses expected 0", obs_q.size()); else passed++;
  endtask

  task automatic test_reset_midwait();
    logic [23:0] o, e;
    int unsigned g;
    bit ok;
    @(negedge clk_i2c);
    vol_req = 1'b1;
    vol_val = 7'h44;
    @(negedge clk_i2c);
    vol_req = 1'b0;
    next_obs(o, g, ok);
    checks++; if (!ok || o !== vol_word(7'h44)) $display("FAIL mid_vol_word: got %h (ok=%0d) expected %h", o, ok, vol_word(7'h44)); else passed++;
    mute_req = 1'b1;
    mute_on = 1'b1;
    @(negedge clk_i2c);
    mute_req = 1'b0;
    reset = 1'b1;
    @(posedge clk_i2c);
    #1;
    checks++; if (i2c_go !== 1'b0) $display("FAIL mid_go: got %b expected 0", i2c_go); else passed++;
    checks++; if (cmd_index !== 4'd0) $display("FAIL mid_cmd_index: got %0d expected 0", cmd_index); else passed++;
    checks++; if (init_done !== 1'b0) $display("FAIL mid_init_done: got %b expected 0", init_done); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b expected 1", busy); else passed++;
    @(negedge clk_i2c);
    obs_q.delete();
    gap_q.delete();
    reset = 1'b0;
    for (int unsigned i = 0; i < 9; i++) exp_q.push_back(golden[i]);
    for (int unsigned i = 0; i < 9; i++) begin
      e = exp_q.pop_front();
      next_obs(o, g, ok);
      checks++; if (!ok || o !== e) $display("FAIL mid_init_word%0d: got %h (ok=%0d) expected %h", i, o, ok, e); else passed++;
    end
    wait_idle(ok);
    repeat (20) @(negedge clk_i2c);
    checks++; if (obs_q.size() != 0) $display("FAIL mid_lost_req: got %0d extra pulses expected 0", obs_q.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_volume();
    test_retry_recover();
    test_retry_fatal();
    test_simultaneous();
    test_coalesce();
    test_reset_midwait();
    checks++; if (stable_err != 0) $display("FAIL data_stable: got %0d changes while go=1 expected 0", stable_err); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/wm8731_cmd_scheduler.md
# wm8731_cmd_scheduler

Sequencing and arbitration front-end for the WM8731 codec's I2C controller. It owns the 24-bit command port of `I2C_Controller` (data, go, end, ack) and plays a 9-entry power-up init sequence. After init it serves runtime volume and mute requests, with bounded retry on NACK. It sits between the audio control logic (volume/mute sources) and `I2C_Controller`, on the 10 kHz I2C clock.

## Interface
Parameters:
- `TOTAL_CMD`, 9, number of init ROM entries
- `MAX_RETRY`, 3, re-sends allowed after a NACK before a command is dropped
- `DEV_ADDR`, 8'h34, WM8731 write address byte
- `VOL_RESET`, 7'h74, reset value of the volume shadow register

Ports:
- `clk_i2c`  in  1  10 kHz I2C controller clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `vol_req`  in  1  volume update request, sampled every cycle
- `vol_val`  in  7  headphone volume code, captured when `vol_req`=1
- `mute_req`  in  1  mute update request
- `mute_on`  in  1  mute level, captured when `mute_req`=1
- `i2c_data`  out  24  {DEV_ADDR, reg[6:0], data[8:0]} to controller
- `i2c_go`  out  1  transfer request to controller
- `i2c_end`  in  1  controller transfer-complete
- `i2c_ack`  in  3  controller ACK bits; any bit high = NACK
- `init_done`  out  1  init sequence completed
- `busy`  out  1  transfer active or work pending
- `error`  out  1  sticky: some command exhausted its retries
- `cmd_index`  out  4  current init ROM index

## Operation
- Init ROM (reg, data): 0:(0F,000) 1:(06,000) 2:(08,002) 3:(02,{2'b00,vol_shadow}) 4:(03,{2'b00,vol_shadow}) 5:(07,001) 6:(09,001) 7:(04,016) 8:(05,006).
- Volume word: reg 02, data {1'b1 (LRHPBOTH), 1'b0, vol_shadow}.
- Mute word: reg 05, data 9'h006 | (mute_shadow<<3).
- Pending flags:
  - `vol_req`=1 sets `vol_pend` and loads `vol_shadow`<=`vol_val`; `mute_req`=1 sets `mute_pend` and loads `mute_shadow`.
  - A request while its flag is already set overwrites the shadow, so the latest value wins.
  - A flag clears when its command is launched in ARB. If set and clear happen in the same cycle, set wins.
- Priority in ARB: init (while !init_done) > mute > volume.
- FSM:
  - ARB (go=0):
    - Select the highest-priority source.
    - Load `i2c_data`, set `i2c_go`<=1, record the source, clear the blank counter, go to WAIT.
    - With nothing pending, stay in ARB.
  - WAIT (go=1):
    - The blank counter increments each cycle, saturating at 2.
    - `i2c_end` is ignored while blank<2.
    - When blank==2 and `i2c_end`=1: `i2c_go`<=0, `ack_q`<=`i2c_ack`, go to CHECK.
  - CHECK (go=0):
    - If `ack_q`!=0 and retry<MAX_RETRY: retry++, `i2c_go`<=1, clear blank, go to WAIT. Data is unchanged.
    - Otherwise: retry<=0; if `ack_q`!=0, set `error`.
    - If the source is init: `cmd_index`++, and `init_done`<=1 when `cmd_index`==TOTAL_CMD-1.
    - Go to ARB.
- A dropped command still advances `cmd_index`; init is never stalled by a NACK.
- `busy` = (state!=ARB) | !init_done | vol_pend | mute_pend, decoded from registers.

## Timing
- Reset values:
  - `i2c_go`=0, `i2c_data`=0, `init_done`=0, `error`=0, `cmd_index`=0.
  - retry=0, `vol_pend`=`mute_pend`=0, `vol_shadow`=VOL_RESET, `mute_shadow`=0, state ARB, `busy`=1.
- First init `i2c_go` rises on the first edge after `reset` deasserts.
- Request latency when idle with `init_done`=1: `vol_req` sampled on edge N → `i2c_go`=1 after edge N+1.
- `i2c_data` changes only on the edge that raises `i2c_go` from ARB, and is stable while `i2c_go`=1.
- Minimum `i2c_go` low time: 2 cycles between distinct commands (CHECK, ARB), 1 cycle before a retry.
- `init_done` rises on the edge leaving CHECK for index 8.
- Reset mid-transfer: on the next edge `i2c_go`=0 and all state returns to reset values. Init restarts from index 0, and pending requests are lost.

## Test plan
- **Init with always-ACK model.** Reset, then the model returns ack=0.
  - Required: exactly 9 `i2c_go` pulses with data 341E00, 340C00, 341002, 340474, 340674, 340E01, 341201, 340816, 340A06.
  - `init_done`=1 after the 9th, `error`=0.
- **Volume update after init.** Pulse `vol_req` with `vol_val`=7'h50.
  - Required: one pulse with data 340550, `i2c_go` high after the 2nd edge, `busy` falls after CHECK.
- **Recoverable and fatal NACK.**
  - Ack=3'b001 for 2 tries, then 0: 3 pulses of identical data, `error`=0.
  - Ack always 3'b010: 4 pulses, `error`=1, `cmd_index` advances.
- **Simultaneous requests during init.** `mute_req`(`mute_on`=1) and `vol_req`(7'h20) in the same cycle during init.
  - Required: after `init_done`, 340A0E first, then 340520.
- **Latest-value-wins coalescing.** `vol_req` 7'h10 then 7'h30 during init.
  - Required: init entries 3/4 carry 030, followed by a single volume write 340530.
- **Reset mid-WAIT.** Assert `reset` during WAIT.
  - Required: `i2c_go`=0 next edge, `cmd_index`=0, `init_done`=0; after release, first word 341E00.
